// File: rtl/sdspi_pkg.sv
// Shared constants and state encodings for the sdspi host-side initiator.
package sdspi_pkg;

  localparam int SECTOR_WORDS = 256;
  localparam int LBA_W        = 27;
  localparam int IDX_W        = $clog2(SECTOR_WORDS);

  localparam logic [23:0] TIMEOUT_DEFAULT = 24'hFFFFFF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WFILL,
    ST_WPAD,
    ST_WAIT_IDLE,
    ST_REQ,
    ST_DROP,
    ST_RADDR,
    ST_ROUT,
    ST_ACK,
    ST_NEXT,
    ST_FINISH
  } host_state_t;

  // Which part of the 4-phase handshake the host is currently waiting in.
  typedef enum logic [1:0] {
    HS_NONE,
    HS_WAIT,
    HS_REQ,
    HS_ACK
  } hs_phase_t;

endpackage

// File: rtl/sdspi_hs_port.sv
// Generic 4-phase initiator: decodes start/ack from the host phase and
// runs the wait-for-edge timeout, which restarts on every phase change.
module sdspi_hs_port
  import sdspi_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic      controller_clk,
  input  logic      reset,
  input  hs_phase_t phase,
  input  logic      dir,
  input  logic      read_done,
  input  logic      write_done,
  output logic      done,
  output logic      timeout,
  output logic      read_start,
  output logic      write_start,
  output logic      read_ack,
  output logic      write_ack
);

  hs_phase_t   phase_q;
  logic [23:0] tmr;
  logic        restart;

  assign restart = (phase != phase_q);

  // tmr holds the number of cycles already spent in the current phase.
  always_ff @(posedge controller_clk) begin
    if (reset) begin
      phase_q <= HS_NONE;
      tmr     <= '0;
    end else begin
      phase_q <= phase;
      if (phase == HS_NONE) tmr <= '0;
      else if (restart)     tmr <= 24'd1;
      else                  tmr <= tmr + 24'd1;
    end
  end

  assign timeout = (phase != HS_NONE) && !restart && (tmr == TIMEOUT_CYCLES - 24'd1);

  assign done        = dir ? write_done : read_done;
  assign read_start  = (phase == HS_REQ) && !dir;
  assign write_start = (phase == HS_REQ) &&  dir;
  assign read_ack    = (phase == HS_ACK) && !dir;
  assign write_ack   = (phase == HS_ACK) &&  dir;

endmodule

// File: rtl/sdspi_host.sv
// Host-side initiator for the sdspi sector buffer: turns an LBA/word-count
// command into a run of sector transfers with valid/ready word streams.
module sdspi_host
  import sdspi_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic             controller_clk,
  input  logic             reset,
  input  logic             cmd_start,
  input  logic             cmd_write,
  input  logic [LBA_W-1:0] cmd_lba,
  input  logic [15:0]      cmd_wcount,
  output logic             cmd_busy,
  output logic             cmd_done,
  output logic             cmd_error,
  output logic [15:0]      rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  input  logic [15:0]      wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [LBA_W-1:0] sdcard_addr,
  input  logic             sdcard_idle,
  output logic             sdcard_read_start,
  input  logic             sdcard_read_done,
  output logic             sdcard_read_ack,
  output logic             sdcard_write_start,
  input  logic             sdcard_write_done,
  output logic             sdcard_write_ack,
  input  logic             sdcard_error,
  output logic [IDX_W-1:0] sdcard_xfer_addr,
  input  logic [15:0]      sdcard_xfer_out,
  output logic             sdcard_xfer_write,
  output logic [15:0]      sdcard_xfer_in
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SECTOR_WORDS - 1);

  host_state_t      state;
  hs_phase_t        phase;
  logic             dir;
  logic [15:0]      remaining;
  logic [IDX_W-1:0] idx;
  logic             hs_done;
  logic             hs_timeout;
  logic             last_word;
  logic             last_idx;

  always_comb begin
    phase = HS_NONE;
    case (state)
      ST_WAIT_IDLE: phase = HS_WAIT;
      ST_REQ:       phase = HS_REQ;
      ST_ACK:       phase = HS_ACK;
      default:      phase = HS_NONE;
    endcase
  end

  sdspi_hs_port #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_hs (
    .controller_clk (controller_clk),
    .reset          (reset),
    .phase          (phase),
    .dir            (dir),
    .read_done      (sdcard_read_done),
    .write_done     (sdcard_write_done),
    .done           (hs_done),
    .timeout        (hs_timeout),
    .read_start     (sdcard_read_start),
    .write_start    (sdcard_write_start),
    .read_ack       (sdcard_read_ack),
    .write_ack      (sdcard_write_ack)
  );

  // The buffer address is held for the whole of ROUT, so xfer_out stays
  // stable while the consumer stalls and needs no local copy.
  assign rd_data   = rd_valid ? sdcard_xfer_out : 16'h0000;
  assign last_word = (remaining == 16'd1);
  assign last_idx  = (idx == LAST_IDX);

  always_ff @(posedge controller_clk) begin
    if (reset) begin
      state             <= ST_IDLE;
      dir               <= 1'b0;
      remaining         <= '0;
      idx               <= '0;
      cmd_busy          <= 1'b0;
      cmd_done          <= 1'b0;
      cmd_error         <= 1'b0;
      rd_valid          <= 1'b0;
      wr_ready          <= 1'b0;
      sdcard_addr       <= '0;
      sdcard_xfer_addr  <= '0;
      sdcard_xfer_write <= 1'b0;
      sdcard_xfer_in    <= '0;
    end else begin
      sdcard_xfer_write <= 1'b0;
      cmd_done          <= 1'b0;
      case (state)
        ST_IDLE: if (cmd_start) begin
          sdcard_addr <= cmd_lba;
          remaining   <= cmd_wcount;
          dir         <= cmd_write;
          idx         <= '0;
          cmd_error   <= 1'b0;
          cmd_busy    <= 1'b1;
          if (cmd_wcount == 16'd0) begin
            cmd_done <= 1'b1;
            state    <= ST_FINISH;
          end else if (cmd_write) begin
            wr_ready <= 1'b1;
            state    <= ST_WFILL;
          end else begin
            state    <= ST_WAIT_IDLE;
          end
        end
        ST_WFILL: if (wr_valid && wr_ready) begin
          sdcard_xfer_write <= 1'b1;
          sdcard_xfer_addr  <= idx;
          sdcard_xfer_in    <= wr_data;
          idx               <= idx + 1'b1;
          remaining         <= remaining - 16'd1;
          if (last_idx) begin
            wr_ready <= 1'b0;
            state    <= ST_WAIT_IDLE;
          end else if (last_word) begin
            wr_ready <= 1'b0;
            state    <= ST_WPAD;
          end
        end
        ST_WPAD: begin
          sdcard_xfer_write <= 1'b1;
          sdcard_xfer_addr  <= idx;
          sdcard_xfer_in    <= 16'h0000;
          idx               <= idx + 1'b1;
          if (last_idx) state <= ST_WAIT_IDLE;
        end
        ST_WAIT_IDLE: begin
          if (hs_timeout) begin
            cmd_error <= 1'b1;
            cmd_done  <= 1'b1;
            state     <= ST_FINISH;
          end else if (sdcard_idle) begin
            state <= ST_REQ;
          end
        end
        // Error wins over a done edge arriving in the same cycle.
        ST_REQ: begin
          if (sdcard_error || hs_timeout) begin
            cmd_error <= 1'b1;
            cmd_done  <= 1'b1;
            state     <= ST_FINISH;
          end else if (hs_done) begin
            state <= ST_DROP;
          end
        end
        ST_DROP: begin
          if (dir) begin
            state <= ST_ACK;
          end else begin
            idx              <= '0;
            sdcard_xfer_addr <= '0;
            state            <= ST_RADDR;
          end
        end
        ST_RADDR: begin
          rd_valid <= 1'b1;
          state    <= ST_ROUT;
        end
        ST_ROUT: if (rd_ready) begin
          rd_valid  <= 1'b0;
          idx       <= idx + 1'b1;
          remaining <= remaining - 16'd1;
          if (last_word || last_idx) begin
            state <= ST_ACK;
          end else begin
            sdcard_xfer_addr <= idx + 1'b1;
            state            <= ST_RADDR;
          end
        end
        ST_ACK: begin
          if (sdcard_error || hs_timeout) begin
            cmd_error <= 1'b1;
            cmd_done  <= 1'b1;
            state     <= ST_FINISH;
          end else if (!hs_done) begin
            state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (remaining == 16'd0) begin
            cmd_done <= 1'b1;
            state    <= ST_FINISH;
          end else begin
            sdcard_addr <= sdcard_addr + 1'b1;
            idx         <= '0;
            if (dir) begin
              wr_ready <= 1'b1;
              state    <= ST_WFILL;
            end else begin
              state    <= ST_WAIT_IDLE;
            end
          end
        end
        ST_FINISH: begin
          cmd_busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdspi_host.sv
// Directed bench for sdspi_host against a small behavioural sdspi card model.
module tb_sdspi_host;

  logic        controller_clk = 1'b0;
  logic        reset;
  logic        cmd_start, cmd_write;
  logic [26:0] cmd_lba;
  logic [15:0] cmd_wcount;
  logic        cmd_busy, cmd_done, cmd_error;
  logic [15:0] rd_data;
  logic        rd_valid, rd_ready;
  logic [15:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [26:0] sdcard_addr;
  logic        sdcard_idle = 1'b1;
  logic        sdcard_read_start, sdcard_read_done, sdcard_read_ack;
  logic        sdcard_write_start, sdcard_write_done, sdcard_write_ack;
  logic        sdcard_error;
  logic [7:0]  sdcard_xfer_addr;
  logic [15:0] sdcard_xfer_out;
  logic        sdcard_xfer_write;
  logic [15:0] sdcard_xfer_in;

  always #5 controller_clk = ~controller_clk;

  sdspi_host #(.TIMEOUT_CYCLES(24'd100)) dut (
    .controller_clk     (controller_clk),
    .reset              (reset),
    .cmd_start          (cmd_start),
    .cmd_write          (cmd_write),
    .cmd_lba            (cmd_lba),
    .cmd_wcount         (cmd_wcount),
    .cmd_busy           (cmd_busy),
    .cmd_done           (cmd_done),
    .cmd_error          (cmd_error),
    .rd_data            (rd_data),
    .rd_valid           (rd_valid),
    .rd_ready           (rd_ready),
    .wr_data            (wr_data),
    .wr_valid           (wr_valid),
    .wr_ready           (wr_ready),
    .sdcard_addr        (sdcard_addr),
    .sdcard_idle        (sdcard_idle),
    .sdcard_read_start  (sdcard_read_start),
    .sdcard_read_done   (sdcard_read_done),
    .sdcard_read_ack    (sdcard_read_ack),
    .sdcard_write_start (sdcard_write_start),
    .sdcard_write_done  (sdcard_write_done),
    .sdcard_write_ack   (sdcard_write_ack),
    .sdcard_error       (sdcard_error),
    .sdcard_xfer_addr   (sdcard_xfer_addr),
    .sdcard_xfer_out    (sdcard_xfer_out),
    .sdcard_xfer_write  (sdcard_xfer_write),
    .sdcard_xfer_in     (sdcard_xfer_in)
  );

  // Card model: done 50 cycles after start, read sector word i = {lba[7:0], i}.
  logic [15:0] rbuf [256];
  logic [15:0] wbuf [256];
  logic [15:0] wcap [4][256];
  logic [26:0] wcap_addr [4];
  logic [2:0]  wcap_n = 3'd0;
  int          mcnt;
  bit          no_done = 1'b0;
  bit          err_inject = 1'b0;

  always @(posedge controller_clk) begin
    if (sdcard_xfer_write) wbuf[sdcard_xfer_addr] <= sdcard_xfer_in;
    sdcard_xfer_out <= rbuf[sdcard_xfer_addr];
    if (reset) begin
      sdcard_read_done  <= 1'b0;
      sdcard_write_done <= 1'b0;
      sdcard_error      <= 1'b0;
      mcnt              <= 0;
    end else begin
      if (sdcard_read_start || sdcard_write_start) begin
        if (!sdcard_read_done && !sdcard_write_done) mcnt <= mcnt + 1;
        if (!no_done && mcnt == 49 && !sdcard_read_done && !sdcard_write_done) begin
          if (sdcard_read_start) begin
            sdcard_read_done <= 1'b1;
            for (int i = 0; i < 256; i++) rbuf[i] <= {sdcard_addr[7:0], 8'(i)};
          end else begin
            sdcard_write_done <= 1'b1;
            if (wcap_n < 3'd4) begin
              for (int i = 0; i < 256; i++) wcap[wcap_n[1:0]][i] <= wbuf[i];
              wcap_addr[wcap_n[1:0]] <= sdcard_addr;
              wcap_n <= wcap_n + 3'd1;
            end
          end
        end
      end else begin
        mcnt <= 0;
      end
      if (sdcard_read_ack)  sdcard_read_done  <= 1'b0;
      if (sdcard_write_ack) sdcard_write_done <= 1'b0;
      if (!(sdcard_read_start || sdcard_write_start || sdcard_read_ack || sdcard_write_ack))
        sdcard_error <= 1'b0;
      else if (err_inject && mcnt == 10 && (sdcard_read_start || sdcard_write_start))
        sdcard_error <= 1'b1;
    end
  end

  typedef struct {
    bit          w;
    logic [26:0] lba;
    logic [15:0] wc;
    int          mode;      // 0: rd_ready=1, 1: stalling pattern
    int          exp_words;
    int          exp_sect;
    int          exp_acks;
    logic [26:0] exp_addr;
  } vec_t;

  typedef struct {
    int          nw, ns, na, nd, t_req, t_done, viol;
    logic [26:0] faddr;
    logic        ferr, fhs, err0, busy;
  } res_t;

  vec_t vt [5];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input vec_t v, input string tag, output res_t r);
    logic [26:0] sec;
    logic [15:0] held, expw;
    bit          stalled, prev_st, prev_ak;
    int          wk;
    r.nw = 0; r.ns = 0; r.na = 0; r.nd = 0; r.t_req = -1; r.t_done = -1; r.viol = 0;
    r.faddr = '0; r.ferr = 0; r.fhs = 0; r.err0 = 0; r.busy = 0;
    stalled = 0; prev_st = 0; prev_ak = 0; held = '0; wk = 0;
    @(negedge controller_clk);
    cmd_start = 1; cmd_write = v.w; cmd_lba = v.lba; cmd_wcount = v.wc;
    @(negedge controller_clk);
    cmd_start = 0;
    r.err0 = cmd_error;
    for (int cyc = 0; cyc < 20000 && r.nd == 0; cyc++) begin
      if ((sdcard_read_start || sdcard_write_start) && !prev_st) begin
        r.ns++;
        if (r.t_req < 0) r.t_req = cyc;
      end
      if ((sdcard_read_ack || sdcard_write_ack) && !prev_ak) r.na++;
      prev_st = sdcard_read_start || sdcard_write_start;
      prev_ak = sdcard_read_ack || sdcard_write_ack;
      if ($countones({sdcard_read_start, sdcard_write_start, sdcard_read_ack, sdcard_write_ack}) > 1)
        r.viol++;
      if (cmd_done) begin
        r.nd++; r.t_done = cyc; r.faddr = sdcard_addr; r.ferr = cmd_error;
        r.fhs = sdcard_read_start | sdcard_write_start | sdcard_read_ack | sdcard_write_ack;
      end
      if (stalled) begin
        chk({tag, "_hold_valid"}, rd_valid, 1);
        chk({tag, "_hold_data"}, rd_data, held);
      end
      rd_ready = (v.mode == 0) || (cyc % 3 != 1);
      if (rd_valid && rd_ready) begin
        sec  = v.lba + 27'(r.nw / 256);
        expw = {sec[7:0], 8'(r.nw)};
        chk({tag, "_rdata"}, rd_data, expw);
        r.nw++;
      end
      stalled = rd_valid && !rd_ready;
      held    = rd_data;
      wr_valid = v.w && (wk < int'(v.wc));
      wr_data  = 16'(wk) ^ 16'hA500;
      if (wr_valid && wr_ready) begin
        wk++;
        r.nw++;
      end
      @(negedge controller_clk);
    end
    wr_valid = 0;
    rd_ready = 0;
    repeat (3) begin
      if (cmd_done) r.nd++;
      @(negedge controller_clk);
    end
    r.busy = cmd_busy;
  endtask

  initial begin
    res_t        r;
    vec_t        hv;
    logic [2:0]  base;
    int          errs, n;
    logic [15:0] expw;

    reset = 1; cmd_start = 0; cmd_write = 0; cmd_lba = '0; cmd_wcount = '0;
    rd_ready = 0; wr_valid = 0; wr_data = '0;

    vt[0] = '{w:0, lba:27'h10,      wc:16'd256, mode:0, exp_words:256, exp_sect:1, exp_acks:1, exp_addr:27'h10};
    vt[1] = '{w:1, lba:27'h10,      wc:16'd300, mode:0, exp_words:300, exp_sect:2, exp_acks:2, exp_addr:27'h11};
    vt[2] = '{w:0, lba:27'h20,      wc:16'd3,   mode:1, exp_words:3,   exp_sect:1, exp_acks:1, exp_addr:27'h20};
    vt[3] = '{w:0, lba:27'h7FFFFFF, wc:16'd512, mode:0, exp_words:512, exp_sect:2, exp_acks:2, exp_addr:27'h0};
    vt[4] = '{w:1, lba:27'h55,      wc:16'd0,   mode:0, exp_words:0,   exp_sect:0, exp_acks:0, exp_addr:27'h55};

    repeat (3) @(negedge controller_clk);
    chk("reset_outs", 32'(|{cmd_busy, cmd_done, cmd_error, rd_data, rd_valid, wr_ready, sdcard_addr,
        sdcard_read_start, sdcard_read_ack, sdcard_write_start, sdcard_write_ack,
        sdcard_xfer_addr, sdcard_xfer_write, sdcard_xfer_in}), 0);
    reset = 0;
    @(negedge controller_clk);

    for (int k = 0; k < 5; k++) begin
      string tag;
      tag = $sformatf("v%0d", k);
      base = wcap_n;
      run_cmd(vt[k], tag, r);
      chk({tag, "_words"}, r.nw, vt[k].exp_words);
      chk({tag, "_sectors"}, r.ns, vt[k].exp_sect);
      chk({tag, "_acks"}, r.na, vt[k].exp_acks);
      chk({tag, "_done_cnt"}, r.nd, 1);
      chk({tag, "_addr"}, r.faddr, vt[k].exp_addr);
      chk({tag, "_error"}, r.ferr, 0);
      chk({tag, "_hs_at_done"}, r.fhs, 0);
      chk({tag, "_excl"}, r.viol, 0);
      chk({tag, "_busy_after"}, r.busy, 0);
      if (k == 1) begin
        chk("w_cap_cnt", wcap_n - base, 2);
        chk("w_sec0_addr", wcap_addr[base[1:0]], 27'h10);
        chk("w_sec1_addr", wcap_addr[base[1:0] + 2'd1], 27'h11);
        errs = 0;
        for (int i = 0; i < 256; i++)
          if (wcap[base[1:0]][i] !== (16'(i) ^ 16'hA500)) errs++;
        chk("w_sec0_data", errs, 0);
        errs = 0;
        for (int i = 0; i < 256; i++) begin
          expw = (i < 44) ? (16'(256 + i) ^ 16'hA500) : 16'h0000;
          if (wcap[base[1:0] + 2'd1][i] !== expw) errs++;
        end
        chk("w_sec1_data", errs, 0);
      end
    end

    // Card never answers: timeout after 100 cycles in REQ.
    no_done = 1;
    hv = '{w:0, lba:27'h40, wc:16'd1, mode:0, exp_words:0, exp_sect:1, exp_acks:0, exp_addr:27'h40};
    run_cmd(hv, "tmo", r);
    chk("tmo_done_cnt", r.nd, 1);
    chk("tmo_error", r.ferr, 1);
    chk("tmo_start_low", r.fhs, 0);
    chk("tmo_latency", 32'((r.t_done - r.t_req >= 98) && (r.t_done - r.t_req <= 102)), 1);
    no_done = 0;
    hv = '{w:0, lba:27'h41, wc:16'd1, mode:0, exp_words:1, exp_sect:1, exp_acks:1, exp_addr:27'h41};
    run_cmd(hv, "clr", r);
    chk("clr_err_on_start", r.err0, 0);
    chk("clr_words", r.nw, 1);
    chk("clr_error", r.ferr, 0);

    // sdcard_error during REQ: error, no ack, single done.
    no_done = 1; err_inject = 1;
    hv = '{w:0, lba:27'h50, wc:16'd4, mode:0, exp_words:0, exp_sect:1, exp_acks:0, exp_addr:27'h50};
    run_cmd(hv, "err", r);
    chk("err_done_cnt", r.nd, 1);
    chk("err_error", r.ferr, 1);
    chk("err_acks", r.na, 0);
    chk("err_words", r.nw, 0);
    no_done = 0; err_inject = 0;

    // Reset while a word sits in ROUT.
    @(negedge controller_clk);
    cmd_start = 1; cmd_write = 0; cmd_lba = 27'h30; cmd_wcount = 16'd256;
    @(negedge controller_clk);
    cmd_start = 0; rd_ready = 0;
    n = 0;
    while (!rd_valid && n < 500) begin
      @(negedge controller_clk);
      n++;
    end
    chk("rst_rvalid_before", rd_valid, 1);
    reset = 1;
    @(negedge controller_clk);
    reset = 0;
    chk("rst_outs", 32'(|{cmd_busy, cmd_done, cmd_error, rd_data, rd_valid, wr_ready, sdcard_addr,
        sdcard_read_start, sdcard_read_ack, sdcard_write_start, sdcard_write_ack,
        sdcard_xfer_addr, sdcard_xfer_write, sdcard_xfer_in}), 0);
    n = 0;
    repeat (20) begin
      @(negedge controller_clk);
      if (cmd_done || cmd_busy) n++;
    end
    chk("rst_no_done", n, 0);
    run_cmd(vt[4], "post_rst", r);
    chk("post_rst_done", r.nd, 1);
    chk("post_rst_addr", r.faddr, 27'h55);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdspi_host.md
Name: sdspi_host

Overview:
Host-side initiator for the sdspi sector buffer controller. It drives the start/done/ack 4-phase handshake and the 256-word buffer port (sdcard_xfer_*) from the controller_clk side. It converts a CPU/DMA command (LBA, direction, word count) into a multi-sector transfer, with a valid/ready word stream on the bus side. It sits between the disk-controller register block (RK/RX emulation) and sdspi.

Parameters:
TIMEOUT_CYCLES, 24'hFFFFFF, max controller_clk cycles spent waiting on any sdspi done/idle edge before a timeout error is declared
SECTOR_WORDS, 256, words per sector; must match the sdspi buffer depth

Ports:
controller_clk  in  1  clock, same clock as the sdspi host interface
reset  in  1  synchronous, active-high
cmd_start  in  1  one-cycle pulse; accepted only in IDLE
cmd_write  in  1  1 = write to card, 0 = read; sampled with cmd_start
cmd_lba  in  27  first sector address; sampled with cmd_start
cmd_wcount  in  16  word count; 0 = no transfer
cmd_busy  out  1  transfer in progress
cmd_done  out  1  one-cycle pulse at the end (success or error)
cmd_error  out  1  sticky until the next cmd_start; set on sdcard_error or timeout
rd_data  out  16  word read from the card
rd_valid  out  1  rd_data is valid; held until rd_ready
rd_ready  in  1  consumer accepts rd_data
wr_data  in  16  word to write to the card
wr_valid  in  1  wr_data is valid
wr_ready  out  1  block accepts wr_data this cycle
sdcard_addr  out  27  current sector LBA
sdcard_idle  in  1  sdspi ready
sdcard_read_start  out  1
sdcard_read_done  in  1
sdcard_read_ack  out  1
sdcard_write_start  out  1
sdcard_write_done  in  1
sdcard_write_ack  out  1
sdcard_error  in  1
sdcard_xfer_addr  out  8  buffer word index
sdcard_xfer_out  in  16  read buffer word; valid 1 cycle after sdcard_xfer_addr
sdcard_xfer_write  out  1  write strobe into the write buffer
sdcard_xfer_in  out  16  word written into the write buffer

Behaviour:
- Reset: every output is 0, FSM goes to IDLE, counters clear. If reset arrives mid-transfer, start/ack drop at once and no cmd_done is issued.
- States: IDLE, WFILL, WPAD, WAIT_IDLE, REQ, DROP, RADDR, ROUT, ACK, NEXT, FINISH.
- IDLE, on cmd_start: latch the LBA into sdcard_addr, latch wcount into the remaining-word count, clear cmd_error, set cmd_busy.
  - wcount = 0: go to FINISH.
  - Otherwise: write goes to WFILL, read goes to WAIT_IDLE.
  - cmd_start outside IDLE is ignored.
- WFILL (write):
  - wr_ready = 1.
  - Each wr_valid & wr_ready writes the word via xfer_write at xfer_addr = word index, increments the index, and decrements the remaining count.
  - When remaining reaches 0 before index 255: go to WPAD.
  - When index 255 is written: go to WAIT_IDLE.
- WPAD: writes 16'h0000 to the rest of the sector, one word per cycle, then WAIT_IDLE.
- WAIT_IDLE: wait for sdcard_idle = 1, then REQ.
- REQ:
  - Assert read_start or write_start.
  - Wait for the matching done = 1, then DROP.
  - Deassert start in DROP.
  - Read goes to RADDR with index 0. Write goes to ACK.
- RADDR: drive xfer_addr = index for one cycle, then ROUT.
- ROUT:
  - rd_data = xfer_out, rd_valid = 1, held stable until rd_ready.
  - On handshake: increment index and decrement remaining.
  - Go to ACK when remaining reaches 0 or index 255 is consumed; otherwise back to RADDR.
  - Words past the word count in the last sector are discarded, never presented.
  - Throughput is 1 word per 2 cycles minimum.
- ACK:
  - Assert the matching ack.
  - Wait for done = 0, deassert ack, then NEXT.
- NEXT:
  - remaining = 0: go to FINISH.
  - Otherwise: sdcard_addr += 1 (27-bit wrap, 27'h7FFFFFF -> 0), index = 0.
  - Then WFILL (write) or WAIT_IDLE (read).
- FINISH: pulse cmd_done for 1 cycle, drop cmd_busy, return to IDLE.
- Timeout counter:
  - Clears on entry to WAIT_IDLE, REQ and ACK; counts every cycle in those states.
  - On reaching TIMEOUT_CYCLES: cmd_error = 1, all start/ack go to 0, then FINISH.
- sdcard_error = 1 while in REQ or ACK: cmd_error = 1, start drops, then ACK-less FINISH. A later cmd_start clears cmd_error.
- Only one of read_start/write_start/read_ack/write_ack is ever high. Start and ack are never high simultaneously.
- Simultaneous done rise and sdcard_error in REQ: error takes priority.

Decomposition:
- Shared package sdspi_pkg: SECTOR_WORDS, LBA width 27, the state enum for sdspi_host, and the default TIMEOUT_CYCLES constant.
- Natural sub-module: sdspi_hs_port, the generic 4-phase initiator (go/start/done/ack plus timeout) instantiated once with a dir select. Everything else stays in sdspi_host.

Test Plan:
- Read, lba=27'h000010, wcount=256, behavioural sdspi model with done after 50 cycles, rd_ready=1 -> read_start high until done, 256 words in buffer order, ack handshake completes, one cmd_done, cmd_error=0.
- Write, wcount=300 with an incrementing pattern -> sector 0x10 gets words 0..255; sector 0x11 gets 44 words then 212 zeros; sdcard_addr steps 0x10 -> 0x11; two write_start/ack cycles.
- Read, wcount=3, rd_ready toggling 1-0-1 -> exactly 3 words, each held stable while stalled; ack issued after the 3rd word.
- lba=27'h7FFFFFF, wcount=512 read -> second sector at sdcard_addr=0.
- Model never raises done, TIMEOUT_CYCLES=100 -> cmd_error=1, read_start low, cmd_done pulse 100±2 cycles after REQ entry; next cmd_start clears cmd_error.
- sdcard_error asserted during REQ, plus reset applied mid-ROUT -> cmd_error=1 then FINISH; after reset all outputs 0, FSM in IDLE, no cmd_done.
